// File: rtl/sipo_frame_ctrl.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional parity, stop bit.
// Good words land in a one-deep holding register with a valid/ready handshake.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StParity, StStop} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_par_err;
  logic             w_last_bit;
  logic             w_par_bad;
  logic             w_stop_sample;
  logic             w_good;
  logic             w_load;

  assign w_last_bit = (r_cnt == CntW'(WIDTH - 1));
  assign w_par_bad  = ((^r_shift) ^ serial_in) != (PARITY_ODD != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bit_en) begin
      unique case (r_state)
        StIdle:   if (!serial_in) w_state_next = StShift;
        StShift:  if (w_last_bit) w_state_next = (PARITY_EN != 0) ? StParity : StStop;
        StParity: w_state_next = StStop;
        StStop:   w_state_next = StIdle;
        default:  w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    busy          = (r_state != StIdle);
    w_stop_sample = (r_state == StStop) && bit_en;
    w_good        = w_stop_sample && serial_in && !r_par_err;
    // A word being consumed on this edge frees the slot for the new one
    w_load        = w_good && (!out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
    end else if (bit_en) begin
      unique case (r_state)
        StIdle: begin
          if (!serial_in) begin
            r_cnt     <= '0;
            r_par_err <= 1'b0;
          end
        end
        StShift: begin
          r_shift <= {serial_in, r_shift[WIDTH-1:1]};
          r_cnt   <= r_cnt + 1'b1;
        end
        StParity: r_par_err <= w_par_bad;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= w_stop_sample && !serial_in;
      parity_err <= w_stop_sample && serial_in && r_par_err;
      overrun    <= w_good && !w_load;
      if (w_load) begin
        out_data  <= r_shift;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Randomized bench for sipo_frame_ctrl: frame-level outcome model plus a holding-slot scoreboard,
// compared against every DUT output on every cycle.
module tb_sipo_frame_ctrl;

  localparam int unsigned W    = 8;
  localparam int unsigned PEN  = 1;
  localparam int unsigned PODD = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         serial_in;
  logic         bit_en;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;
  logic         busy;

  sipo_frame_ctrl #(
    .WIDTH     (W),
    .PARITY_EN (PEN),
    .PARITY_ODD(PODD)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .bit_en    (bit_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic         m_valid, m_ferr, m_perr, m_ovr, m_busy;
  logic [W-1:0] m_data;
  logic         f_stop, f_perr;
  logic [W-1:0] f_word;
  logic         start_now = 1'b0;
  logic         stop_now  = 1'b0;
  int           ready_mode = 0;  // 0 random, 1 always ready, 2 never ready
  int           gap_lo = 0;
  int           gap_hi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_ready();
    case (ready_mode)
      1:       out_ready = 1'b1;
      2:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    m_ferr = 1'b0;
    m_perr = 1'b0;
    m_ovr  = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_busy  = 1'b0;
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (bit_en && start_now) m_busy = 1'b1;
      if (bit_en && stop_now) begin
        m_busy = 1'b0;
        if (!f_stop) m_ferr = 1'b1;
        else if (f_perr) m_perr = 1'b1;
        else if (!m_valid) begin
          m_valid = 1'b1;
          m_data  = f_word;
        end else m_ovr = 1'b1;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("parity_err", 32'(parity_err), 32'(m_perr));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    bit_en = 1'($urandom_range(0, 1));
    set_ready();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bit_en    = 1'($urandom_range(0, 1));
      serial_in = 1'b1;
      set_ready();
      tick();
    end
  endtask

  task automatic send_bit(input logic b, input logic st, input logic sp);
    int gaps;
    gaps = $urandom_range(gap_hi, gap_lo);
    for (int i = 0; i < gaps; i++) begin
      bit_en    = 1'b0;
      serial_in = 1'($urandom_range(0, 1));
      set_ready();
      tick();
    end
    bit_en    = 1'b1;
    serial_in = b;
    start_now = st;
    stop_now  = sp;
    set_ready();
    tick();
    start_now = 1'b0;
    stop_now  = 1'b0;
    bit_en    = 1'b0;
  endtask

  // abort_after < W resets the DUT after that many data bits
  task automatic send_frame(input logic [W-1:0] data, input logic pbit, input logic stop,
                            input int abort_after);
    f_word = data;
    f_stop = stop;
    f_perr = (PEN != 0) && (((^data) ^ pbit) != (PODD != 0));
    send_bit(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < int'(W); i++) begin
      if (i == abort_after) begin
        do_reset();
        return;
      end
      send_bit(data[i], 1'b0, 1'b0);
    end
    if (PEN != 0) send_bit(pbit, 1'b0, 1'b0);
    send_bit(stop, 1'b0, 1'b1);
  endtask

  function automatic logic good_par(input logic [W-1:0] d);
    return (^d) ^ (PODD != 0);
  endfunction

  initial begin
    logic [W-1:0] d;
    logic         p;
    logic         s;
    rst       = 1'b1;
    serial_in = 1'b1;
    bit_en    = 1'b0;
    out_ready = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_busy    = 1'b0;
    do_reset();
    do_reset();

    // Directed: basic frame, bit_en every cycle
    ready_mode = 1;
    send_frame(8'hA5, 1'b0, 1'b1, W);
    check("t1_data", 32'(out_data), 32'hA5);
    check("t1_valid", 32'(out_valid), 32'd1);
    idle(2);

    // bit_en every 4th cycle
    gap_lo = 3; gap_hi = 3;
    send_frame(8'hA5, 1'b0, 1'b1, W);
    gap_lo = 0; gap_hi = 0;
    idle(2);

    // Parity error, then framing error followed by back-to-back good frame
    send_frame(8'h01, 1'b0, 1'b1, W);
    idle(1);
    send_frame(8'h3C, good_par(8'h3C), 1'b0, W);
    send_frame(8'h5A, good_par(8'h5A), 1'b1, W);
    check("t4_data", 32'(out_data), 32'h5A);
    idle(2);

    // Overrun with consumer stalled, then drain
    ready_mode = 2;
    send_frame(8'h11, good_par(8'h11), 1'b1, W);
    send_frame(8'h22, good_par(8'h22), 1'b1, W);
    idle(3);
    check("t5_hold", 32'(out_data), 32'h11);
    ready_mode = 1;
    idle(2);
    check("t5_drained", 32'(out_valid), 32'd0);

    // Mid-frame reset, then full frame
    send_frame(8'h7E, good_par(8'h7E), 1'b1, 4);
    send_frame(8'h7E, good_par(8'h7E), 1'b1, W);
    check("t6_data", 32'(out_data), 32'h7E);
    idle(2);

    // Randomized frames
    ready_mode = 0;
    gap_lo = 3; gap_hi = 0;
    for (int n = 0; n < 300; n++) begin
      d = W'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      s = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) send_frame(d, p, s, $urandom_range(0, W - 1));
      else send_frame(d, p, s, W);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    ready_mode = 1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
